// File: rtl/sync_fifo_ctrl.sv
// Pointer/flag controller for a synchronous FIFO driving an external register file.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_ctrl #(
    parameter int ADD_WIDTH = 4,
    parameter int AF_LEVEL  = (2 ** ADD_WIDTH) - 2,
    parameter int AE_LEVEL  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic                 rd_en,
    output logic                 mem_w_en,
    output logic [ADD_WIDTH-1:0] w_addr,
    output logic [ADD_WIDTH-1:0] r_addr,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADD_WIDTH:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [ADD_WIDTH:0] AF_LVL = (ADD_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADD_WIDTH:0] AE_LVL = (ADD_WIDTH + 1)'(AE_LEVEL);

    // One extra wrap bit on each pointer separates full from empty.
    logic [ADD_WIDTH:0] wr_ptr_reg, wr_ptr_next;
    logic [ADD_WIDTH:0] rd_ptr_reg, rd_ptr_next;
    logic               wr_acc;
    logic               rd_acc;

    // Status is decoded from the registered pointers only.
    assign empty        = (wr_ptr_reg == rd_ptr_reg);
    assign full         = (wr_ptr_reg[ADD_WIDTH-1:0] == rd_ptr_reg[ADD_WIDTH-1:0]) &&
                          (wr_ptr_reg[ADD_WIDTH] != rd_ptr_reg[ADD_WIDTH]);
    assign count        = wr_ptr_reg - rd_ptr_reg;
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);
    assign w_addr       = wr_ptr_reg[ADD_WIDTH-1:0];
    assign r_addr       = rd_ptr_reg[ADD_WIDTH-1:0];

    // A write into a full FIFO is still taken when the head leaves in the same cycle.
    assign wr_acc   = wr_en & (~full | rd_en);
    assign rd_acc   = rd_en & ~empty;
    assign mem_w_en = wr_acc;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (wr_acc) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_reg;
    logic underflow_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            overflow_reg  <= overflow_reg | (wr_en & full & ~rd_en);
            underflow_reg <= underflow_reg | (rd_en & empty);
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed and random checks of sync_fifo_ctrl against a pointer model and a data scoreboard.
module tb_sync_fifo_ctrl;

    localparam int AW = 4;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic          rd_en;
    logic          mem_w_en;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] r_addr;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    sync_fifo_ctrl #(.ADD_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .mem_w_en     (mem_w_en),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Register file the controller drives; its contents survive reset.
    logic [7:0] mem [D];
    logic [7:0] wdata = 8'd0;
    always @(posedge clk) begin
        if (mem_w_en) mem[w_addr] <= wdata;
    end

    int checks = 0;
    int passes = 0;
    int m_wp   = 0;
    int m_rp   = 0;
    bit verbose = 1'b1;
    logic [7:0] sb [$];

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam int ERR_ON = 1;
`else
    localparam int ERR_ON = 0;
`endif

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One clock of traffic: checks acceptance and read data before the edge, state after it.
    task automatic cycle(input bit w, input bit r);
        int  mcnt;
        bit  wacc;
        bit  racc;
        mcnt  = (m_wp - m_rp) & (2 * D - 1);
        wr_en = w;
        rd_en = r;
        #1;
        wacc = w & ((mcnt != D) | r);
        racc = r & (mcnt != 0);
        check("mem_w_en", int'(mem_w_en), int'(wacc));
        if (racc) begin
            check("r_addr", int'(r_addr), m_rp % D);
            check("rdata", int'(mem[r_addr]), int'(sb[0]));
            void'(sb.pop_front());
        end
        if (wacc) sb.push_back(wdata);
        @(posedge clk);
        #1;
        if (wacc) begin
            m_wp  = (m_wp + 1) % (2 * D);
            wdata = wdata + 8'd1;
        end
        if (racc) m_rp = (m_rp + 1) % (2 * D);
        mcnt = (m_wp - m_rp) & (2 * D - 1);
        check("count", int'(count), mcnt);
        check("full", int'(full), int'(mcnt == D));
        check("empty", int'(empty), int'(mcnt == 0));
        check("almost_full", int'(almost_full), int'(mcnt >= D - 2));
        check("almost_empty", int'(almost_empty), int'(mcnt <= 2));
        check("w_addr", int'(w_addr), m_wp % D);
        if (verbose)
            $display("t=%0t wr=%0b rd=%0b wacc=%0b racc=%0b count=%0d full=%0b empty=%0b",
                     $time, w, r, wacc, racc, count, full, empty);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, int'(count), 0);
        check({tag, "_empty"}, int'(empty), 1);
        check({tag, "_almost_empty"}, int'(almost_empty), 1);
        check({tag, "_full"}, int'(full), 0);
        check({tag, "_almost_full"}, int'(almost_full), 0);
        check({tag, "_w_addr"}, int'(w_addr), 0);
        check({tag, "_r_addr"}, int'(r_addr), 0);
        check({tag, "_overflow"}, int'(overflow), 0);
        check({tag, "_underflow"}, int'(underflow), 0);
    endtask

    initial begin
        int wbias;
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst_n = 1'b0;
        #13;
        check_reset_state("reset");
        $display("t=%0t reset held count=%0d empty=%0b", $time, count, empty);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill with 16 writes: almost_full from count 14, full and w_addr back to 0 after the 16th.
        for (int i = 0; i < D; i++) cycle(1'b1, 1'b0);
        check("fill_count", int'(count), 16);
        check("fill_full", int'(full), 1);
        check("fill_almost_full", int'(almost_full), 1);
        check("fill_w_addr", int'(w_addr), 0);

        // 17th write alone is rejected.
        cycle(1'b1, 1'b0);
        check("ovf_count", int'(count), 16);
        check("ovf_w_addr", int'(w_addr), 0);
        check("ovf_r_addr", int'(r_addr), 0);
        check("ovf_flag", int'(overflow), ERR_ON);

        // Full with write and read together for 20 cycles: both pointers wrap through 0.
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1);
        check("pass_count", int'(count), 16);
        check("pass_w_addr", int'(w_addr), 4);
        check("pass_r_addr", int'(r_addr), 4);
        check("pass_overflow_sticky", int'(overflow), ERR_ON);

        // Drain, then write and read together while empty: only the write is taken.
        for (int i = 0; i < D; i++) cycle(1'b0, 1'b1);
        check("drain_empty", int'(empty), 1);
        check("drain_underflow", int'(underflow), 0);
        cycle(1'b1, 1'b1);
        check("empty_rw_count", int'(count), 1);
        check("empty_rw_r_addr", int'(r_addr), 4);
        check("empty_rw_underflow", int'(underflow), ERR_ON);

        // Bring occupancy to 9, then reset between clock edges.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);
        check("pre_reset_count", int'(count), 9);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        $display("t=%0t mid-cycle reset count=%0d empty=%0b", $time, count, empty);
        sb.delete();
        m_wp = 0;
        m_rp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Requests honoured right after reset release.
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);

        // Random traffic with drifting write bias so both boundaries are visited.
        verbose = 1'b0;
        wbias   = 50;
        for (int i = 0; i < 10000; i++) begin
            if (i % 400 == 0) wbias = (wbias == 75) ? 25 : 75;
            cycle(($urandom_range(0, 99) < wbias), ($urandom_range(0, 99) >= wbias));
        end
        $display("t=%0t random phase done count=%0d", $time, count);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
